// File: rtl/bram_fifo.sv
// ---------------------------------------------------------------------------
// bram_fifo
//   Single-clock FIFO whose storage is one simple dual-port block RAM
//   (bram_dual_port, also defined in this file). The head word is presented
//   straight from the RAM read register. No output flop is added after it.
//
// Ports
//   clk       : single clock, all state on the rising edge
//   rst_n     : synchronous active-low reset
//   in_data   : write word
//   in_valid  : producer offers in_data
//   in_ready  : FIFO accepts a word this cycle (count < NumWords, not in reset)
//   out_data  : head-of-FIFO word (RAM read port output)
//   out_valid : out_data holds a valid word
//   out_ready : consumer takes out_data
//   flush     : synchronous clear of all contents (overrides push/pop)
//   count     : occupancy 0..NumWords (RAM words + presented word)
// ---------------------------------------------------------------------------
module bram_fifo #(
  parameter int WordLengthBits = 8,
  parameter int NumWords       = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WordLengthBits-1:0]     in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WordLengthBits-1:0]     out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          flush,
  output logic [$clog2(NumWords):0]     count
);

  localparam int AW = $clog2(NumWords);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(NumWords);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   mem_count_reg, mem_count_next;
  logic          out_valid_reg, out_valid_next;

  logic          push;
  logic          pop;
  logic          load;
  logic          ram_wr_en;
  logic [AW-1:0] ram_rd_addr;

  assign count     = mem_count_reg + {{AW{1'b0}}, out_valid_reg};
  assign in_ready  = (count < FULL_COUNT) & rst_n;
  assign out_valid = out_valid_reg;

  assign push = in_valid & in_ready;
  assign pop  = out_valid_reg & out_ready;

  // Fetch the next word from RAM whenever the output slot is free or is
  // being vacated this cycle.
  assign load = (mem_count_reg != '0) & (~out_valid_reg | pop);

  // When not fetching, keep re-reading the slot of the presented word so the
  // RAM output register holds its value. That slot cannot be overwritten:
  // reaching it would need mem_count = NumWords-1 with out_valid set, which
  // is a full FIFO and therefore in_ready is low.
  assign ram_rd_addr = load ? rd_ptr_reg : (rd_ptr_reg - PTR_ONE);

  // A flushed push is dropped so the RAM is left untouched.
  assign ram_wr_en = push & ~flush;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    mem_count_next = mem_count_reg;
    out_valid_next = out_valid_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (load) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    mem_count_next = mem_count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, load};

    if (load) begin
      out_valid_next = 1'b1;
    end else if (pop) begin
      out_valid_next = 1'b0;
    end

    if (flush) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      mem_count_next = '0;
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_count_reg <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      mem_count_reg <= mem_count_next;
      out_valid_reg <= out_valid_next;
    end
  end

  bram_dual_port #(
    .WordLengthBits (WordLengthBits),
    .NumWords       (NumWords)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (in_data),
    .rd_addr (ram_rd_addr),
    .rd_data (out_data)
  );

endmodule

// ---------------------------------------------------------------------------
// bram_dual_port
//   Simple dual-port RAM: one write port, one read port, registered read
//   (1-cycle latency). A read and a write to the same address on the same
//   edge return the old contents (read-first). Contents are never reset.
//
// Ports
//   clk     : clock
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write word
//   rd_addr : read address, sampled every edge
//   rd_data : registered read word
// ---------------------------------------------------------------------------
module bram_dual_port #(
  parameter int WordLengthBits = 8,
  parameter int NumWords       = 128
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [$clog2(NumWords)-1:0]   wr_addr,
  input  logic [WordLengthBits-1:0]     wr_data,
  input  logic [$clog2(NumWords)-1:0]   rd_addr,
  output logic [WordLengthBits-1:0]     rd_data
);

  logic [WordLengthBits-1:0] mem_reg [NumWords];
  logic [WordLengthBits-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Separate process with non-blocking update gives read-first behaviour.
  always_ff @(posedge clk) begin
    rd_data_reg <= mem_reg[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: doc/bram_fifo.md
BRAM_FIFO -- requirements
Module: bram_fifo

Interface
REQ-001 SHALL have parameter WordLengthBits, default 8, data word width in bits.
REQ-002 SHALL have parameter NumWords, default 128, storage depth in words; SHALL be a power of two, >= 4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_data  input  WordLengthBits  write word.
REQ-006 SHALL have port in_valid  input  1  producer offers in_data.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a word this cycle.
REQ-008 SHALL have port out_data  output  WordLengthBits  head-of-FIFO word.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_data.
REQ-011 SHALL have port flush  input  1  synchronous clear of all contents.
REQ-012 SHALL have port count  output  $clog2(NumWords)+1  occupancy, 0..NumWords.

Function
REQ-013 SHALL store words in one internal bram_dual_port instance (WordLengthBits, NumWords), with its 1-cycle read latency and read-first collision behaviour.
REQ-014 Push = in_valid & in_ready at a rising edge; pop = out_valid & out_ready at a rising edge.
REQ-015 in_ready SHALL equal (count < NumWords) & rst_n, combinationally.
REQ-016 On push, in_data SHALL be written to BRAM at wr_ptr; wr_ptr SHALL increment modulo NumWords.
REQ-017 Internal mem_count = words in BRAM not yet loaded to output; count SHALL equal mem_count + out_valid.
REQ-018 Load SHALL occur when mem_count > 0 and (out_valid == 0 or pop); BRAM read address SHALL be rd_ptr; rd_ptr SHALL increment modulo NumWords; out_valid SHALL be 1 after that edge.
REQ-019 When not loading, BRAM read address SHALL be rd_ptr - 1 (mod NumWords) so out_data stays stable.
REQ-020 Pop without load SHALL clear out_valid at that edge.
REQ-021 out_data SHALL be the BRAM read port output directly; no extra output register.
REQ-022 Latency: word pushed into an empty FIFO at edge k SHALL show out_valid = 1 after edge k+1.
REQ-023 Throughput: with mem_count > 0 and out_ready held high, one pop per cycle SHALL be sustained.
REQ-024 While out_valid & !out_ready, out_data and out_valid SHALL hold unchanged on every edge.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; push is allowed when count == NumWords only if in_ready, i.e. never (no push-through when full).
REQ-026 Words SHALL emerge in push order; pointer wrap at NumWords-1 -> 0 SHALL be seamless.
REQ-027 The slot at rd_ptr-1 holding the presented word SHALL never be overwritten while out_valid = 1.
REQ-028 flush high at an edge SHALL zero wr_ptr, rd_ptr, mem_count, out_valid; it overrides any push or pop at that edge.

Reset
REQ-029 rst_n low at a rising edge SHALL zero wr_ptr, rd_ptr, mem_count, out_valid; count = 0 after that edge.
REQ-030 While rst_n low, in_ready SHALL be 0 and no BRAM write SHALL occur; reset mid-stream SHALL discard all contents.
REQ-031 BRAM contents are not cleared by reset or flush; no stale word SHALL ever be presented.

Verification (NumWords = 8, WordLengthBits = 8)
REQ-032 Push 8'hAA into empty FIFO at edge k, out_ready = 0 -> out_valid = 1, out_data = 8'hAA after edge k+1; unchanged for 5 further edges; count = 1.
REQ-033 Push 8'h01..8'h08 back-to-back -> in_ready = 0, count = 8; extra push of 8'hFF ignored; drain with out_ready = 1 -> 8'h01..8'h08 on consecutive cycles, then out_valid = 0, count = 0.
REQ-034 Stream 20 words 8'h00..8'h13, in_valid and out_ready high every cycle -> all 20 emerge in order across pointer wrap; count stays <= 2.
REQ-035 out_ready toggled pseudo-randomly during a 12-word stream -> no loss, duplication or reorder; out_data stable whenever stalled.
REQ-036 Fill 5 words, assert flush with in_valid = out_ready = 1 -> next cycle count = 0, out_valid = 0, pushed word discarded; next push 8'h55 appears 2 edges later.
REQ-037 Fill 3 words, drive rst_n low one edge -> count = 0, out_valid = 0, in_ready = 0 during reset, 1 after.
